// File: rtl/stopwatch_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_cmd_ctrl
//
// Decodes single-byte commands received from a UART and drives a stopwatch:
//   'S'/'s' -> one-cycle sw_start_o pulse (run/stop toggle)
//   'C'/'c' -> one-cycle sw_clear_o pulse (clear to 00:00:00)
//   'T'/'t' -> snapshot hours/minutes/seconds and stream "HH:MM:SS" (plus CR LF
//              when CRLF_EN=1) to the UART TX with a valid/ready handshake.
// Any other byte is ignored.
//
// Parameters
//   CRLF_EN     1: report is 10 bytes ending in CR LF; 0: report is 8 bytes.
//
// Ports
//   clk_i       single clock, all state updates on the rising edge
//   reset_ni    synchronous active-low reset
//   rx_data_i   received byte, qualified by rx_valid_i
//   rx_valid_i  one-cycle strobe marking rx_data_i valid
//   hours_i     current stopwatch hours   (binary, 0..63)
//   minutes_i   current stopwatch minutes (binary, 0..63)
//   seconds_i   current stopwatch seconds (binary, 0..63)
//   tx_ready_i  UART TX accepts tx_data_o when tx_valid_o && tx_ready_i
//   sw_start_o  registered one-cycle toggle pulse
//   sw_clear_o  registered one-cycle clear pulse
//   tx_data_o   report byte, 0x00 when idle
//   tx_valid_o  report byte valid, held until accepted
//   busy_o      high while a report is in progress
// -----------------------------------------------------------------------------
module stopwatch_cmd_ctrl #(
    parameter bit CRLF_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic [5:0] hours_i,
    input  logic [5:0] minutes_i,
    input  logic [5:0] seconds_i,
    input  logic       tx_ready_i,
    output logic       sw_start_o,
    output logic       sw_clear_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    output logic       busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Index of the final report byte: LF when terminated, seconds-ones otherwise.
    localparam logic [3:0] LAST_IDX = CRLF_EN ? 4'd9 : 4'd7;

    // Splits a 0..63 binary value into {tens, ones} decimal digits. A compare
    // ladder is used instead of a generic divider since the range is tiny.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        if      (v >= 6'd60) begin tens = 4'd6; rem = v - 6'd60; end
        else if (v >= 6'd50) begin tens = 4'd5; rem = v - 6'd50; end
        else if (v >= 6'd40) begin tens = 4'd4; rem = v - 6'd40; end
        else if (v >= 6'd30) begin tens = 4'd3; rem = v - 6'd30; end
        else if (v >= 6'd20) begin tens = 4'd2; rem = v - 6'd20; end
        else if (v >= 6'd10) begin tens = 4'd1; rem = v - 6'd10; end
        else                 begin tens = 4'd0; rem = v;         end
        return {tens, rem[3:0]};
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [5:0] snap_h_q, snap_h_d;
    logic [5:0] snap_m_q, snap_m_d;
    logic [5:0] snap_s_q, snap_s_d;
    logic       sw_start_q, sw_start_d;
    logic       sw_clear_q, sw_clear_d;

    logic is_toggle;
    logic is_clear;
    logic is_report;

    // Command decode; bytes without rx_valid_i never reach the state logic.
    always_comb begin
        is_toggle = rx_valid_i && ((rx_data_i == 8'h53) || (rx_data_i == 8'h73));
        is_clear  = rx_valid_i && ((rx_data_i == 8'h43) || (rx_data_i == 8'h63));
        is_report = rx_valid_i && ((rx_data_i == 8'h54) || (rx_data_i == 8'h74));
    end

    // NOTE: every signal written here gets its default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_h_d   = snap_h_q;
        snap_m_d   = snap_m_q;
        snap_s_d   = snap_s_q;
        // Toggle/clear act in either state; a byte decodes to at most one of them.
        sw_start_d = is_toggle;
        sw_clear_d = is_clear;

        unique case (state_q)
            IDLE: begin
                if (is_report) begin
                    state_d  = SEND;
                    idx_d    = 4'd0;
                    snap_h_d = hours_i;
                    snap_m_d = minutes_i;
                    snap_s_d = seconds_i;
                end
            end
            SEND: begin
                // A report command here is dropped: no branch reacts to is_report.
                if (tx_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            snap_h_q   <= 6'd0;
            snap_m_q   <= 6'd0;
            snap_s_q   <= 6'd0;
            sw_start_q <= 1'b0;
            sw_clear_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_h_q   <= snap_h_d;
            snap_m_q   <= snap_m_d;
            snap_s_q   <= snap_s_d;
            sw_start_q <= sw_start_d;
            sw_clear_q <= sw_clear_d;
        end
    end

    // Report byte selection works only from the snapshot, so live time inputs
    // changing mid-report cannot corrupt the message.
    logic [7:0] bcd_h, bcd_m, bcd_s;
    logic [7:0] tx_data;

    always_comb begin
        bcd_h   = to_bcd(snap_h_q);
        bcd_m   = to_bcd(snap_m_q);
        bcd_s   = to_bcd(snap_s_q);
        tx_data = 8'h00;
        if (state_q == SEND) begin
            case (idx_q)
                4'd0:    tx_data = ascii_digit(bcd_h[7:4]);
                4'd1:    tx_data = ascii_digit(bcd_h[3:0]);
                4'd2:    tx_data = 8'h3A;
                4'd3:    tx_data = ascii_digit(bcd_m[7:4]);
                4'd4:    tx_data = ascii_digit(bcd_m[3:0]);
                4'd5:    tx_data = 8'h3A;
                4'd6:    tx_data = ascii_digit(bcd_s[7:4]);
                4'd7:    tx_data = ascii_digit(bcd_s[3:0]);
                4'd8:    tx_data = 8'h0D;
                4'd9:    tx_data = 8'h0A;
                default: tx_data = 8'h00;
            endcase
        end
    end

    assign sw_start_o = sw_start_q;
    assign sw_clear_o = sw_clear_q;
    assign tx_data_o  = tx_data;
    assign tx_valid_o = (state_q == SEND);
    assign busy_o     = (state_q == SEND);

endmodule

// File: doc/stopwatch_cmd_ctrl.md
STOPWATCH_CMD_CTRL -- requirements
Module: stopwatch_cmd_ctrl

Interface
REQ-001 Parameter: CRLF_EN, 1, when 1 each report ends with CR (0x0D) LF (0x0A); when 0 the report is 8 bytes with no terminator.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 rx_data  input  8  received byte from UART RX.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-006 hours  input  6  current stopwatch hours, binary.
REQ-007 minutes  input  6  current stopwatch minutes, binary.
REQ-008 seconds  input  6  current stopwatch seconds, binary.
REQ-009 sw_start  output  1  one-cycle pulse; toggles stopwatch run/stop.
REQ-010 sw_clear  output  1  one-cycle pulse; clears stopwatch to 00:00:00.
REQ-011 tx_data  output  8  byte to UART TX.
REQ-012 tx_valid  output  1  tx_data valid; held until accepted.
REQ-013 tx_ready  input  1  UART TX accepts tx_data when tx_valid && tx_ready.
REQ-014 busy  output  1  high while a report is in progress.

Function
REQ-015 Commands are decoded only on cycles with rx_valid=1: 'S'/'s' (0x53/0x73) = toggle, 'C'/'c' (0x43/0x63) = clear, 'T'/'t' (0x54/0x74) = report; all other bytes are ignored with no output effect.
REQ-016 Toggle sampled at edge N drives sw_start=1 for exactly the cycle after edge N, then 0.
REQ-017 Clear sampled at edge N drives sw_clear=1 for exactly the cycle after edge N, then 0.
REQ-018 sw_start and sw_clear are registered outputs and are never high in the same cycle.
REQ-019 FSM states: IDLE, SEND; reset state IDLE.
REQ-020 IDLE -> SEND on the edge sampling a report command; on that same edge hours/minutes/seconds are captured into a snapshot register and byte index is set to 0.
REQ-021 In SEND: tx_valid=1, busy=1, and tx_data = report byte [index], derived from the snapshot only.
REQ-022 Report byte order: H tens, H ones, ':' (0x3A), M tens, M ones, ':', S tens, S ones, then CR, LF when CRLF_EN=1.
REQ-023 Digits are ASCII: tens = '0' + v/10, ones = '0' + v%10, for the full 0..63 input range (63 -> "63").
REQ-024 Index advances by 1 on each edge with tx_valid && tx_ready; tx_data and tx_valid do not change while tx_ready=0.
REQ-025 On acceptance of the last byte (index 9, or 7 when CRLF_EN=0), SEND -> IDLE; tx_valid=0 and busy=0 the following cycle.
REQ-026 In IDLE: tx_valid=0, busy=0, tx_data=0x00.
REQ-027 A report command received while in SEND is dropped; the report in flight is not restarted or extended.
REQ-028 Toggle or clear received while in SEND is acted on per REQ-016/017; the snapshot and report in flight are unaffected.
REQ-029 Back-to-back commands on consecutive cycles are each decoded independently; toggles on consecutive cycles yield sw_start pulses on consecutive cycles.
REQ-030 tx_ready held high continuously yields one byte accepted per cycle: the full report completes in 10 cycles (8 when CRLF_EN=0).

Reset
REQ-031 With reset=0 at a rising edge: state=IDLE, index=0, snapshot=0, sw_start=0, sw_clear=0, tx_valid=0, tx_data=0x00, busy=0 from the following cycle.
REQ-032 Reset during SEND aborts the report; no remaining bytes are sent after reset releases.
REQ-033 A command byte with rx_valid=1 on a cycle where reset=0 is discarded.

Verification
REQ-034 rx 'S' at edge N -> sw_start=1 only in cycle N+1; rx 'c' -> sw_clear=1 only in the cycle after its edge; rx 'x' -> no pulse, tx_valid stays 0.
REQ-035 Inputs 12/05/09, rx 'T', tx_ready=1 -> tx bytes 0x31 0x32 0x3A 0x30 0x35 0x3A 0x30 0x39 0x0D 0x0A on 10 consecutive cycles, then busy=0.
REQ-036 Inputs 23/59/59, 'T', then inputs change to 0/0/0 mid-report with tx_ready toggling 1/0 -> report still "23:59:59\r\n"; tx_data is stable during every ready-low cycle.
REQ-037 During SEND: rx 'T' -> ignored, exactly 10 bytes total; rx 'S' -> sw_start pulse, report uninterrupted.
REQ-038 reset=0 asserted after byte 4 has been accepted -> tx_valid=0 the next cycle; after release, no further bytes are sent and busy=0 until a new 'T' arrives.
REQ-039 CRLF_EN=0, inputs 0/0/0, 'T' -> "00:00:00" as 8 bytes, then busy=0.
